// File: rtl/mult_div_pkg.sv
// Shared constants, state encoding and op encodings for the sequential multiply/divide unit.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int ITERATIONS    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and keep the trial
// difference only when it stays non-negative.
module div_restoring_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One extra top bit keeps the borrow visible even if the shifted remainder uses bit WIDTH.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {2'b00, divisor_i};
        q_o     = ~trial[WIDTH+1];
        rem_o   = q_o ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit with
// HI/LO result registers for the multicycle datapath.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITERATIONS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH+1:0] booth_q, booth_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   quot_next;
    logic [WIDTH:0]     acc_sum;
    logic [2*WIDTH+1:0] booth_next;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               accept;
    logic               last_iter;

    div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (quot_q[WIDTH-1]),
        .divisor_i (opnd_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign quot_next = {quot_q[WIDTH-2:0], step_q};
    assign abs_a     = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
    assign abs_b     = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;
    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_iter = (cnt_q == CNT_W'(ITERATIONS - 1));

    // Booth accumulator is one bit wider than the operand so that -2^(WIDTH-1) can be subtracted safely.
    always_comb begin
        unique case (booth_q[1:0])
            2'b01:   acc_sum = booth_q[2*WIDTH+1:WIDTH+1] + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   acc_sum = booth_q[2*WIDTH+1:WIDTH+1] - {opnd_q[WIDTH-1], opnd_q};
            default: acc_sum = booth_q[2*WIDTH+1:WIDTH+1];
        endcase
        booth_next = {acc_sum[WIDTH], acc_sum, booth_q[WIDTH:1]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        booth_d    = booth_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        opnd_d     = opnd_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            IDLE: ;
            MULT: begin
                booth_d = booth_next;
                cnt_d   = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = DONE;
                    hi_d    = booth_next[2*WIDTH:WIDTH+1];
                    lo_d    = booth_next[WIDTH:1];
                end
            end
            DIV: begin
                rem_d  = step_rem;
                quot_d = quot_next;
                cnt_d  = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = DONE;
                    lo_d    = neg_quot_q ? (~quot_next + 1'b1) : quot_next;
                    hi_d    = neg_rem_q ? (~step_rem[WIDTH-1:0] + 1'b1) : step_rem[WIDTH-1:0];
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A divide by zero skips the iterations and leaves HI/LO untouched.
        if (accept) begin
            cnt_d = '0;
            dbz_d = 1'b0;
            if (op == OP_DIV) begin
                if (operand_b == '0) begin
                    state_d = DONE;
                    dbz_d   = 1'b1;
                end else begin
                    state_d    = DIV;
                    rem_d      = '0;
                    quot_d     = abs_a;
                    opnd_d     = abs_b;
                    neg_quot_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    neg_rem_d  = operand_a[WIDTH-1];
                end
            end else begin
                state_d = MULT;
                booth_d = {{(WIDTH+1){1'b0}}, operand_b, 1'b0};
                opnd_d  = operand_a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            booth_q    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            opnd_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            booth_q    <= booth_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            opnd_q     <= opnd_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = (state_q == MULT) || (state_q == DIV);
    assign done        = (state_q == DONE);
    assign div_by_zero = (state_q == DONE) && dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a behavioural model pushes the expected HI/LO/flag and
// completion cycle for each accepted request, and a monitor pops them on every done pulse.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cycle;
    } expect_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic        done;
    logic        divByZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          vectorCount = 0;
    int          miscompares = 0;
    int          cycle = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    expect_t     sbQueue[$];
    expect_t     monExp;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operandA),
        .operand_b   (operandB),
        .busy        (busy),
        .done        (done),
        .div_by_zero (divByZero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Reference results come from 64-bit integer arithmetic, which truncates toward zero like MIPS div.
    function automatic expect_t model(input logic opv, input logic [31:0] a, input logic [31:0] b, input int cyc);
        expect_t e;
        longint  sa = longint'($signed(a));
        longint  sb = longint'($signed(b));
        longint  p, q, r;
        e.dbz   = 1'b0;
        e.cycle = cyc + 33;
        if (opv == 1'b0) begin
            p       = sa * sb;
            modelHi = p[63:32];
            modelLo = p[31:0];
        end else if (b == 32'd0) begin
            e.dbz   = 1'b1;
            e.cycle = cyc + 1;
        end else begin
            q       = sa / sb;
            r       = sa % sb;
            modelHi = r[31:0];
            modelLo = q[31:0];
        end
        e.hi = modelHi;
        e.lo = modelLo;
        return e;
    endfunction

    task automatic applyStimulus(input logic opv, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = opv;
        operandA = a;
        operandB = b;
        sbQueue.push_back(model(opv, a, b, cycle));
        @(negedge clk);
        start    = 1'b0;
        op       = 1'($urandom);
        operandA = $urandom;
        operandB = $urandom;
    endtask

    task automatic waitForIdle();
        for (int i = 0; i < 200; i++) begin
            if (sbQueue.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain", 64'(sbQueue.size()), 64'd0);
        sbQueue.delete();
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                monExp = sbQueue.pop_front();
                checkOutput("hi", 64'(hi), 64'(monExp.hi));
                checkOutput("lo", 64'(lo), 64'(monExp.lo));
                checkOutput("div_by_zero", 64'(divByZero), 64'(monExp.dbz));
                checkOutput("done_cycle", 64'(cycle), 64'(monExp.cycle));
            end
        end
        if (busy && done) checkOutput("busy_done_overlap", 64'd1, 64'd0);
    end

    initial begin
        int busyCycles;
        int doneCount;
        logic [31:0] ra, rb;
        logic        ro;

        reset    = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        operandA = '0;
        operandB = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_dbz", 64'(divByZero), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        $display("[TB] multiply 7 * -3 with busy length");
        @(negedge clk);
        applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD);
        busyCycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            if (busy) busyCycles++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", 64'(busyCycles), 64'd32);
        checkOutput("mul_7_hi", 64'(modelHi), 64'hFFFF_FFFF);
        checkOutput("mul_7_lo", 64'(modelLo), 64'hFFFF_FFEB);
        waitForIdle();

        $display("[TB] multiply extremes");
        @(negedge clk);
        applyStimulus(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        waitForIdle();
        checkOutput("mul_max_hi", 64'(hi), 64'h3FFF_FFFF);
        @(negedge clk);
        applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000);
        waitForIdle();
        checkOutput("mul_min_hi", 64'(hi), 64'h4000_0000);

        $display("[TB] signed divides");
        @(negedge clk);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        waitForIdle();
        checkOutput("div_m7_2_lo", 64'(lo), 64'hFFFF_FFFD);
        @(negedge clk);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
        waitForIdle();
        checkOutput("div_7_m2_hi", 64'(hi), 64'd1);

        $display("[TB] divide by zero keeps HI/LO");
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_2211, 32'h0000_0100);
        waitForIdle();
        @(negedge clk);
        applyStimulus(1'b1, 32'd5, 32'd0);
        checkOutput("dbz_busy", 64'(busy), 64'd0);
        checkOutput("dbz_done", 64'(done), 64'd1);
        checkOutput("dbz_hi", 64'(hi), 64'h11);
        checkOutput("dbz_lo", 64'(lo), 64'h22);
        waitForIdle();

        $display("[TB] overflow divide then back-to-back multiply");
        @(negedge clk);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            @(negedge clk);
        end
        checkOutput("ovf_lo", 64'(lo), 64'h8000_0000);
        applyStimulus(1'b0, 32'd3, 32'd4);
        checkOutput("b2b_done_fell", 64'(done), 64'd0);
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        waitForIdle();
        checkOutput("b2b_lo", 64'(lo), 64'd12);

        $display("[TB] start while busy is ignored");
        @(negedge clk);
        applyStimulus(1'b0, 32'h1234_5678, 32'hFEDC_BA98);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        op       = 1'b1;
        operandA = 32'd100;
        operandB = 32'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_ignored_start", 64'(busy), 64'd1);
        waitForIdle();

        $display("[TB] random operations");
        for (int n = 0; n < 8; n++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = ro ? ((n % 2 == 0) ? 32'($urandom_range(1, 5000)) : -32'($urandom_range(1, 5000))) : $urandom;
            @(negedge clk);
            applyStimulus(ro, ra, rb);
            waitForIdle();
        end

        $display("[TB] reset during multiply");
        @(negedge clk);
        applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'd0);
        checkOutput("abort_lo", 64'(lo), 64'd0);
        sbQueue.delete();
        modelHi = '0;
        modelLo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort_no_done", 64'(doneCount), 64'd0);
        checkOutput("abort_idle_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
